oldland_memstage: RTL and testbench
===================================

Name: oldland_memstage

Overview:
- Pipeline stage directly downstream of execute and upstream of register writeback.
- Takes the registered memory request from execute (MAR, MDR, width, load/store strobes) plus the pending writeback (value, enable, rd select).
- Runs one data-bus transaction per load/store, with byte-lane steering and load-data extraction, and stalls the pipeline until the bus acks.
- Forwards the final register write and raises data_abort on bus error, timeout or misalignment.

Parameters:
TIMEOUT_CYCLES, 255, max cycles d_access is held without d_ack/d_error before abort; 0 disables the timeout.

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
load_in  input  1  memory load request
store_in  input  1  memory store request
width_in  input  2  access width: 2'b10 = 32-bit, 2'b01 = 16-bit, 2'b00 = 8-bit
mar  input  32  byte address
mdr  input  32  store data (low bits used for sub-word)
wr_val_in  input  32  non-load writeback value
wr_result_in  input  1  instruction writes rd
rd_sel_in  input  4  destination register
busy  output  1  stall upstream; inputs must be held while high
d_addr  output  32  bus address, word aligned ([1:0]=0)
d_bytesel  output  4  active byte lanes
d_wr_val  output  32  lane-replicated store data
d_wr_en  output  1  bus write
d_access  output  1  bus request, held until ack/error
d_data  input  32  bus read data
d_ack  input  1  transaction complete
d_error  input  1  transaction failed
reg_wr_en  output  1  writeback enable
reg_wr_sel  output  4  writeback register
reg_wr_val  output  32  writeback data
data_abort  output  1  one-cycle abort pulse

Behaviour:
- FSM states: IDLE, WAIT.
- start = state==IDLE && (load_in || store_in).
- busy = start || (state==WAIT && !d_ack && !d_error && !timeout). Combinational; low in the completion cycle.
- IDLE, start: latch addr/width/rd/load flag; next edge go to WAIT with d_access=1, d_wr_en=store_in.
- IDLE, no start: next edge reg_wr_en=wr_result_in, reg_wr_sel=rd_sel_in, reg_wr_val=wr_val_in. One-cycle pass-through.
- WAIT: d_access, d_addr, d_bytesel, d_wr_val and d_wr_en stay stable. Timeout counter increments each cycle.
- WAIT, d_ack (d_error=0): next edge IDLE, d_access=0.
  - Load: reg_wr_en=1, reg_wr_val=extracted data.
  - Store: reg_wr_en=0.
- WAIT, d_error, or counter reaches TIMEOUT_CYCLES (when nonzero): next edge IDLE, data_abort=1 for one cycle, reg_wr_en=0.
- d_ack and d_error in the same cycle: error wins.
- Lane steering:
  - Byte: bytesel = 1 << mar[1:0]; data = mdr[7:0] replicated x4.
  - Half: bytesel = mar[1] ? 4'b1100 : 4'b0011; data = mdr[15:0] replicated x2.
  - Word: bytesel = 4'b1111.
  - width 2'b11 is treated as word.
- Load extraction (zero-extended):
  - Byte: d_data[8*mar[1:0] +: 8].
  - Half: d_data[16*mar[1] +: 16].
  - Word: d_data.
- Latency: request accepted at cycle 0, d_access high cycles 1..k (ack at k), reg_wr_en at k+1. Minimum load-to-writeback is 2 cycles.
- load_in && store_in together: store takes priority.
- Reset (any state, including mid-transaction): next edge IDLE. d_access, d_wr_en, d_bytesel, reg_wr_en, data_abort = 0. reg_wr_sel, reg_wr_val, d_addr, d_wr_val = 0. Timeout counter cleared. A late d_ack after reset is ignored.

Optional Feature:
- Macro: OLDLAND_ALIGN_CHECK_EN.
- Defined: misaligned requests (half with mar[0]=1; word with mar[1:0]!=0) raise no bus access. Next edge data_abort=1, reg_wr_en=0, state stays IDLE; busy is high only in the request cycle.
- Undefined: low address bits below the access width are ignored (forced to 0) and the access proceeds normally.

Test Plan:
- Word load mar=0x1000, d_ack 3 cycles after d_access rises, d_data=0xCAFEBABE -> d_addr=0x1000, bytesel=4'b1111; busy high 3 cycles; reg_wr_val=0xCAFEBABE, reg_wr_en one cycle.
- Byte store mar=0x2003, mdr=0x000000A5 -> d_bytesel=4'b1000, d_wr_val=0xA5A5A5A5, d_wr_en=1; reg_wr_en=0 after ack.
- Half load mar=0x2002, d_data=0x12345678 -> reg_wr_val=0x00001234.
- d_error on word load -> data_abort one-cycle pulse, reg_wr_en=0, busy drops. Repeat with TIMEOUT_CYCLES=4 and no ack -> abort after 4 wait cycles.
- Non-memory op wr_val_in=0x55, wr_result_in=1, rd_sel_in=3 -> next cycle reg_wr_en=1, reg_wr_sel=3, reg_wr_val=0x55, busy never high.
- rst asserted in WAIT, then d_ack pulsed -> d_access=0 next edge, no writeback, no abort. With OLDLAND_ALIGN_CHECK_EN, word load mar=0x1002 -> data_abort, d_access never high.

Source files
------------

// File: rtl/oldland_memstage.sv
// oldland_memstage: memory pipeline stage between execute and writeback.
//
// Issues one data-bus transaction per load/store and stalls upstream until
// the bus responds. It steers store data and byte lanes, extracts and
// zero-extends load data, and forwards the final register write. It pulses
// data_abort on bus error, timeout or (optionally) misalignment.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   load_in, store_in, width_in   memory request from execute
//   mar, mdr                      byte address, store data
//   wr_val_in, wr_result_in,      pending non-load writeback
//   rd_sel_in
//   busy                          combinational stall to upstream
//   d_addr, d_bytesel, d_wr_val,  data-bus request (registered)
//   d_wr_en, d_access
//   d_data, d_ack, d_error        data-bus response
//   reg_wr_en, reg_wr_sel,        writeback (registered)
//   reg_wr_val
//   data_abort                    one-cycle abort pulse
//
// Parameters:
//   TIMEOUT_CYCLES  max cycles d_access is held without a response
//                   (0 disables the timeout)
//
// Build option:
//   OLDLAND_ALIGN_CHECK_EN  when defined, misaligned half/word requests
//                           abort without a bus access. Otherwise the low
//                           address bits below the access width are
//                           ignored.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no bus transaction; pass-through writeback or accept request
// WAIT  | d_access held, waiting for d_ack / d_error / timeout

module oldland_memstage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_in,
  input  logic        store_in,
  input  logic [1:0]  width_in,
  input  logic [31:0] mar,
  input  logic [31:0] mdr,
  input  logic [31:0] wr_val_in,
  input  logic        wr_result_in,
  input  logic [3:0]  rd_sel_in,
  output logic        busy,
  output logic [31:0] d_addr,
  output logic [3:0]  d_bytesel,
  output logic [31:0] d_wr_val,
  output logic        d_wr_en,
  output logic        d_access,
  input  logic [31:0] d_data,
  input  logic        d_ack,
  input  logic        d_error,
  output logic        reg_wr_en,
  output logic [3:0]  reg_wr_sel,
  output logic [31:0] reg_wr_val,
  output logic        data_abort
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  bytesel_q, bytesel_d;
  logic [31:0] wr_val_q, wr_val_d;
  logic        wr_en_q, wr_en_d;
  logic        access_q, access_d;
  logic        is_load_q, is_load_d;
  logic [1:0]  width_q, width_d;
  logic [1:0]  lane_q, lane_d;
  logic [3:0]  rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        reg_wr_en_q, reg_wr_en_d;
  logic [3:0]  reg_wr_sel_q, reg_wr_sel_d;
  logic [31:0] reg_wr_val_q, reg_wr_val_d;
  logic        abort_q, abort_d;

  logic        start;
  logic        timeout;
  logic        is_byte, is_half;
  logic [1:0]  req_lane;
  logic [3:0]  req_bytesel;
  logic [31:0] req_wr_val;
  logic [31:0] load_data;

  assign start   = (state_q == IDLE) && (load_in || store_in);
  assign timeout = (TIMEOUT_CYCLES != 0) && (state_q == WAIT) &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign busy    = start ||
                   ((state_q == WAIT) && !d_ack && !d_error && !timeout);

  assign is_byte = (width_in == 2'b00);
  assign is_half = (width_in == 2'b01);

`ifdef OLDLAND_ALIGN_CHECK_EN
  logic misalign;
  assign misalign = (is_half && mar[0]) ||
                    (!is_byte && !is_half && (mar[1:0] != 2'b00));
`endif

  // Request-side steering; sub-width address bits are dropped so a
  // misaligned access (when not aborted) lands on the aligned lanes.
  always_comb begin
    req_lane    = 2'b00;
    req_bytesel = 4'b1111;
    req_wr_val  = mdr;
    if (is_byte) begin
      req_lane    = mar[1:0];
      req_bytesel = 4'b0001 << mar[1:0];
      req_wr_val  = {4{mdr[7:0]}};
    end else if (is_half) begin
      req_lane    = {mar[1], 1'b0};
      req_bytesel = mar[1] ? 4'b1100 : 4'b0011;
      req_wr_val  = {2{mdr[15:0]}};
    end
  end

  always_comb begin
    load_data = d_data;
    case (width_q)
      2'b00:   load_data = {24'd0, d_data[{lane_q, 3'b000} +: 8]};
      2'b01:   load_data = {16'd0, d_data[{lane_q[1], 4'b0000} +: 16]};
      default: load_data = d_data;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    bytesel_d    = bytesel_q;
    wr_val_d     = wr_val_q;
    wr_en_d      = wr_en_q;
    access_d     = access_q;
    is_load_d    = is_load_q;
    width_d      = width_q;
    lane_d       = lane_q;
    rd_d         = rd_q;
    cnt_d        = cnt_q;
    reg_wr_en_d  = 1'b0;
    reg_wr_sel_d = reg_wr_sel_q;
    reg_wr_val_d = reg_wr_val_q;
    abort_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef OLDLAND_ALIGN_CHECK_EN
          if (misalign) begin
            abort_d = 1'b1;
          end else begin
`else
          begin
`endif
            state_d   = WAIT;
            access_d  = 1'b1;
            wr_en_d   = store_in;
            is_load_d = !store_in;  // store wins when both are requested
            addr_d    = {mar[31:2], 2'b00};
            bytesel_d = req_bytesel;
            wr_val_d  = req_wr_val;
            width_d   = width_in;
            lane_d    = req_lane;
            rd_d      = rd_sel_in;
            cnt_d     = '0;
          end
        end else begin
          reg_wr_en_d  = wr_result_in;
          reg_wr_sel_d = rd_sel_in;
          reg_wr_val_d = wr_val_in;
        end
      end

      WAIT: begin
        if (d_error || timeout) begin
          state_d  = IDLE;
          access_d = 1'b0;
          wr_en_d  = 1'b0;
          abort_d  = 1'b1;
        end else if (d_ack) begin
          state_d      = IDLE;
          access_d     = 1'b0;
          wr_en_d      = 1'b0;
          reg_wr_en_d  = is_load_q;
          reg_wr_sel_d = rd_q;
          if (is_load_q) begin
            reg_wr_val_d = load_data;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      bytesel_q    <= '0;
      wr_val_q     <= '0;
      wr_en_q      <= 1'b0;
      access_q     <= 1'b0;
      is_load_q    <= 1'b0;
      width_q      <= '0;
      lane_q       <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
      reg_wr_en_q  <= 1'b0;
      reg_wr_sel_q <= '0;
      reg_wr_val_q <= '0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      bytesel_q    <= bytesel_d;
      wr_val_q     <= wr_val_d;
      wr_en_q      <= wr_en_d;
      access_q     <= access_d;
      is_load_q    <= is_load_d;
      width_q      <= width_d;
      lane_q       <= lane_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      reg_wr_en_q  <= reg_wr_en_d;
      reg_wr_sel_q <= reg_wr_sel_d;
      reg_wr_val_q <= reg_wr_val_d;
      abort_q      <= abort_d;
    end
  end

  assign d_addr     = addr_q;
  assign d_bytesel  = bytesel_q;
  assign d_wr_val   = wr_val_q;
  assign d_wr_en    = wr_en_q;
  assign d_access   = access_q;
  assign reg_wr_en  = reg_wr_en_q;
  assign reg_wr_sel = reg_wr_sel_q;
  assign reg_wr_val = reg_wr_val_q;
  assign data_abort = abort_q;

endmodule

// File: tb/tb_oldland_memstage.sv
// Directed bench for oldland_memstage (instance built with TIMEOUT_CYCLES=4).
module tb_oldland_memstage;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_in, store_in;
  logic [1:0]  width_in;
  logic [31:0] mar, mdr, wr_val_in;
  logic        wr_result_in;
  logic [3:0]  rd_sel_in;
  logic        busy;
  logic [31:0] d_addr;
  logic [3:0]  d_bytesel;
  logic [31:0] d_wr_val;
  logic        d_wr_en, d_access;
  logic [31:0] d_data;
  logic        d_ack, d_error;
  logic        reg_wr_en;
  logic [3:0]  reg_wr_sel;
  logic [31:0] reg_wr_val;
  logic        data_abort;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  oldland_memstage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .load_in(load_in), .store_in(store_in), .width_in(width_in),
    .mar(mar), .mdr(mdr),
    .wr_val_in(wr_val_in), .wr_result_in(wr_result_in), .rd_sel_in(rd_sel_in),
    .busy(busy),
    .d_addr(d_addr), .d_bytesel(d_bytesel), .d_wr_val(d_wr_val),
    .d_wr_en(d_wr_en), .d_access(d_access),
    .d_data(d_data), .d_ack(d_ack), .d_error(d_error),
    .reg_wr_en(reg_wr_en), .reg_wr_sel(reg_wr_sel), .reg_wr_val(reg_wr_val),
    .data_abort(data_abort)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Runs one load/store starting at a negedge. waits = response-free WAIT
  // cycles before the final cycle, in which d_ack/d_error are driven as given
  // (both low in the final cycle means the timeout is expected to fire).
  task automatic mem_op(input string nm, input logic ld, input logic st,
                        input logic [1:0] w, input logic [31:0] a,
                        input logic [31:0] md, input int waits,
                        input logic ack, input logic err,
                        input logic [31:0] rdata, input logic [31:0] e_addr,
                        input logic [3:0] e_bs, input logic [31:0] e_wv,
                        input logic e_wen, input logic e_rwen,
                        input logic e_abort, input logic [31:0] e_rval);
    int busy_n;
    load_in = ld; store_in = st; width_in = w; mar = a; mdr = md;
    rd_sel_in = 4'd9; wr_result_in = 1'b0; wr_val_in = 32'hDEAD0000;
    #1 chk({nm, ".busy_req"}, busy, 1);
    busy_n = busy ? 1 : 0;
    @(negedge clk);
    chk({nm, ".access"}, d_access, 1);
    chk({nm, ".addr"}, d_addr, e_addr);
    chk({nm, ".bytesel"}, d_bytesel, e_bs);
    if (e_wen) chk({nm, ".wr_val"}, d_wr_val, e_wv);
    chk({nm, ".wr_en"}, d_wr_en, e_wen);
    for (int i = 0; i < waits; i++) begin
      #1 if (busy) busy_n++;
      @(negedge clk);
    end
    d_ack = ack; d_error = err; d_data = rdata;
    #1 chk({nm, ".busy_done"}, busy, 0);
    chk({nm, ".access_held"}, d_access, 1);
    chk({nm, ".addr_held"}, d_addr, e_addr);
    @(negedge clk);
    d_ack = 1'b0; d_error = 1'b0; load_in = 1'b0; store_in = 1'b0;
    #1 chk({nm, ".reg_wr_en"}, reg_wr_en, e_rwen);
    if (e_rwen) begin
      chk({nm, ".reg_wr_val"}, reg_wr_val, e_rval);
      chk({nm, ".reg_wr_sel"}, reg_wr_sel, 9);
    end
    chk({nm, ".abort"}, data_abort, e_abort);
    chk({nm, ".access_off"}, d_access, 0);
    chk({nm, ".busy_idle"}, busy, 0);
    chk({nm, ".busy_cycles"}, busy_n, waits + 1);
    @(negedge clk);
    chk({nm, ".abort_pulse"}, data_abort, 0);
    chk({nm, ".reg_wr_en_pulse"}, reg_wr_en, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; load_in = 0; store_in = 0; width_in = 0; mar = 0; mdr = 0;
    wr_val_in = 0; wr_result_in = 0; rd_sel_in = 0; d_data = 0; d_ack = 0; d_error = 0;
    repeat (3) @(negedge clk);
    chk("rst.access", d_access, 0);
    chk("rst.wr_en", d_wr_en, 0);
    chk("rst.bytesel", d_bytesel, 0);
    chk("rst.addr", d_addr, 0);
    chk("rst.wr_val", d_wr_val, 0);
    chk("rst.reg_wr_en", reg_wr_en, 0);
    chk("rst.reg_wr_sel", reg_wr_sel, 0);
    chk("rst.reg_wr_val", reg_wr_val, 0);
    chk("rst.abort", data_abort, 0);
    chk("rst.busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    //      name       ld st w      mar           mdr           wt ack err rdata         e_addr        bs       e_wv          wen rwen abt e_rval
    mem_op("wload",   1, 0, 2'b10, 32'h1000,     32'h0,        2, 1, 0, 32'hCAFEBABE, 32'h1000,     4'b1111, 32'h0,        0, 1, 0, 32'hCAFEBABE);
    mem_op("bstore",  0, 1, 2'b00, 32'h2003,     32'h000000A5, 0, 1, 0, 32'h0,        32'h2000,     4'b1000, 32'hA5A5A5A5, 1, 0, 0, 32'h0);
    mem_op("hload",   1, 0, 2'b01, 32'h2002,     32'h0,        1, 1, 0, 32'h12345678, 32'h2000,     4'b1100, 32'h0,        0, 1, 0, 32'h00001234);
    mem_op("bload",   1, 0, 2'b00, 32'h3001,     32'h0,        0, 1, 0, 32'h11223344, 32'h3000,     4'b0010, 32'h0,        0, 1, 0, 32'h00000033);
    mem_op("hstore",  0, 1, 2'b01, 32'h40,       32'hFFFFBEEF, 1, 1, 0, 32'h0,        32'h40,       4'b0011, 32'hBEEFBEEF, 1, 0, 0, 32'h0);
    mem_op("ldst",    1, 1, 2'b10, 32'h50,       32'h12345678, 0, 1, 0, 32'h99999999, 32'h50,       4'b1111, 32'h12345678, 1, 0, 0, 32'h0);
    mem_op("w11",     1, 0, 2'b11, 32'h60,       32'h0,        0, 1, 0, 32'hA1B2C3D4, 32'h60,       4'b1111, 32'h0,        0, 1, 0, 32'hA1B2C3D4);
    mem_op("err",     1, 0, 2'b10, 32'h1000,     32'h0,        1, 0, 1, 32'hCAFEBABE, 32'h1000,     4'b1111, 32'h0,        0, 0, 1, 32'h0);
    mem_op("ackerr",  1, 0, 2'b10, 32'h1004,     32'h0,        0, 1, 1, 32'h5555AAAA, 32'h1004,     4'b1111, 32'h0,        0, 0, 1, 32'h0);
    mem_op("tmo",     1, 0, 2'b10, 32'h1008,     32'h0,        3, 0, 0, 32'h0,        32'h1008,     4'b1111, 32'h0,        0, 0, 1, 32'h0);

    // Non-memory pass-through.
    wr_result_in = 1; wr_val_in = 32'h55; rd_sel_in = 4'd3;
    #1 chk("pass.busy", busy, 0);
    @(negedge clk);
    wr_result_in = 0;
    chk("pass.reg_wr_en", reg_wr_en, 1);
    chk("pass.reg_wr_sel", reg_wr_sel, 3);
    chk("pass.reg_wr_val", reg_wr_val, 32'h55);
    chk("pass.access", d_access, 0);
    @(negedge clk);
    chk("pass.reg_wr_en_off", reg_wr_en, 0);

    // Reset during WAIT, then a late ack that must be ignored.
    load_in = 1; width_in = 2'b10; mar = 32'h7000;
    @(negedge clk);
    chk("rstw.access", d_access, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; load_in = 0; d_ack = 1; d_data = 32'h77777777;
    #1 chk("rstw.access_off", d_access, 0);
    chk("rstw.addr", d_addr, 0);
    chk("rstw.busy", busy, 0);
    @(negedge clk);
    d_ack = 0;
    chk("rstw.reg_wr_en", reg_wr_en, 0);
    chk("rstw.abort", data_abort, 0);
    chk("rstw.access_late", d_access, 0);
    @(negedge clk);

`ifdef OLDLAND_ALIGN_CHECK_EN
    load_in = 1; width_in = 2'b10; mar = 32'h1002;
    #1 chk("mis.busy_req", busy, 1);
    @(negedge clk);
    load_in = 0;
    #1 chk("mis.abort", data_abort, 1);
    chk("mis.access", d_access, 0);
    chk("mis.reg_wr_en", reg_wr_en, 0);
    chk("mis.busy", busy, 0);
    @(negedge clk);
    chk("mis.abort_pulse", data_abort, 0);
    chk("mis.access_after", d_access, 0);
    load_in = 1; width_in = 2'b01; mar = 32'h2003;
    @(negedge clk);
    load_in = 0;
    #1 chk("mish.abort", data_abort, 1);
    chk("mish.access", d_access, 0);
    @(negedge clk);
`else
    mem_op("misw",    1, 0, 2'b10, 32'h1002,     32'h0,        0, 1, 0, 32'h0BADF00D, 32'h1000,     4'b1111, 32'h0,        0, 1, 0, 32'h0BADF00D);
    mem_op("mish",    1, 0, 2'b01, 32'h2003,     32'h0,        0, 1, 0, 32'h12345678, 32'h2000,     4'b1100, 32'h0,        0, 1, 0, 32'h00001234);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
